// File: rtl/snoop_pkg.sv
// Shared constants and types for the snoop responder: line states, bus ops,
// FSM encoding and WriteBack bit positions.
package snoop_pkg;

  localparam logic [2:0] LS_INVALID  = 3'b000;
  localparam logic [2:0] LS_SHARED   = 3'b001;
  localparam logic [2:0] LS_MODIFIED = 3'b010;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_RD_MISS = 3'b001;
  localparam logic [2:0] OP_WR_MISS = 3'b010;
  localparam logic [2:0] OP_INV     = 3'b011;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WB   = 1'b1
  } fsm_t;

  localparam int WB_ACTIVE_BIT = 0;
  localparam int WB_ABORT_BIT  = 1;

endpackage

// File: rtl/snoop_wb_timer.sv
// Write-back duration counter: load WB_CYCLES-1, count down while running;
// done is high whenever the count reads zero.
module snoop_wb_timer #(
  parameter int WB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CW = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WB_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/snoop_responder.sv
// Bus-side snoop responder: direct-mapped tag/state array, invalidate/downgrade
// on snooped misses, timed write-back of MODIFIED lines. Optional SNOOP_STATS_EN adds hit/WB counters.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LINES     = 4,
  parameter int WB_CYCLES = 3
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              BusValid,
  input  logic [2:0]        BusOp,
  input  logic [ADDR_W-1:0] BusAddr,
  output logic              BusReady,
  input  logic              FillValid,
  input  logic [ADDR_W-1:0] FillAddr,
  input  logic [2:0]        FillState,
  output logic              FillReady,
  output logic [1:0]        WriteBack,
  output logic [ADDR_W-1:0] WbAddr,
  input  logic [ADDR_W-1:0] QueryAddr,
  output logic [2:0]        QueryState
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]       SnoopHits,
  output logic [15:0]       WbCount
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [TAG_W-1:0] tag_q   [LINES];
  logic [2:0]       state_q [LINES];

  fsm_t             fsm_q, fsm_d;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [2:0]       wb_next_q, wb_next_d;
  logic             wb_start, timer_done, in_wb;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic [2:0]       upd_state;

  logic [IDX_W-1:0] bus_idx, fill_idx, query_idx, wb_idx;
  logic [TAG_W-1:0] bus_tag, fill_tag, query_tag;
  logic             bus_hit, snoop_op, accept, fill_apply;
  logic [2:0]       fill_state;

  assign bus_idx   = BusAddr[IDX_W-1:0];
  assign bus_tag   = BusAddr[ADDR_W-1:IDX_W];
  assign fill_idx  = FillAddr[IDX_W-1:0];
  assign fill_tag  = FillAddr[ADDR_W-1:IDX_W];
  assign query_idx = QueryAddr[IDX_W-1:0];
  assign query_tag = QueryAddr[ADDR_W-1:IDX_W];
  assign wb_idx    = wb_addr_q[IDX_W-1:0];

  assign in_wb    = (fsm_q == FSM_WB);
  assign BusReady = !in_wb;
  assign accept   = BusValid && BusReady;
  assign snoop_op = (BusOp == OP_RD_MISS) || (BusOp == OP_WR_MISS) || (BusOp == OP_INV);
  assign bus_hit  = (tag_q[bus_idx] == bus_tag) && (state_q[bus_idx] != LS_INVALID);

  // Snoop wins a same-index collision, so a fill never races a snoop update.
  assign FillReady  = !in_wb && !(BusValid && snoop_op && (fill_idx == bus_idx));
  assign fill_apply = FillValid && FillReady;
  assign fill_state = (FillState > LS_MODIFIED) ? LS_INVALID : FillState;

  assign QueryState = (tag_q[query_idx] == query_tag) ? state_q[query_idx] : LS_INVALID;
  assign WbAddr     = wb_addr_q;

  always_comb begin
    WriteBack                = 2'b00;
    WriteBack[WB_ACTIVE_BIT] = in_wb;
    WriteBack[WB_ABORT_BIT]  = in_wb;
  end

  always_comb begin
    fsm_d     = fsm_q;
    wb_start  = 1'b0;
    wb_next_d = LS_INVALID;
    upd_en    = 1'b0;
    upd_idx   = bus_idx;
    upd_state = LS_INVALID;
    case (fsm_q)
      FSM_IDLE: begin
        if (accept && bus_hit) begin
          case (BusOp)
            OP_RD_MISS: begin
              if (state_q[bus_idx] == LS_MODIFIED) begin
                fsm_d     = FSM_WB;
                wb_start  = 1'b1;
                wb_next_d = LS_SHARED;
              end
            end
            OP_WR_MISS: begin
              if (state_q[bus_idx] == LS_MODIFIED) begin
                fsm_d     = FSM_WB;
                wb_start  = 1'b1;
                wb_next_d = LS_INVALID;
              end else begin
                upd_en = 1'b1;
              end
            end
            OP_INV:  upd_en = 1'b1;
            default: ;
          endcase
        end
      end
      FSM_WB: begin
        if (timer_done) begin
          fsm_d     = FSM_IDLE;
          upd_en    = 1'b1;
          upd_idx   = wb_idx;
          upd_state = wb_next_q;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  snoop_wb_timer #(.WB_CYCLES(WB_CYCLES)) u_timer (
    .clk   (Clock),
    .rst_n (Reset_n),
    .load  (wb_start),
    .run   (in_wb),
    .done  (timer_done)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      fsm_q     <= FSM_IDLE;
      wb_addr_q <= '0;
      wb_next_q <= LS_INVALID;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= LS_INVALID;
      end
    end else begin
      fsm_q <= fsm_d;
      if (wb_start) begin
        wb_addr_q <= BusAddr;
        wb_next_q <= wb_next_d;
      end
      if (upd_en) state_q[upd_idx] <= upd_state;
      if (fill_apply) begin
        tag_q[fill_idx]   <= fill_tag;
        state_q[fill_idx] <= fill_state;
      end
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      SnoopHits <= '0;
      WbCount   <= '0;
    end else begin
      if (accept && snoop_op && bus_hit && (SnoopHits != 16'hFFFF)) SnoopHits <= SnoopHits + 16'd1;
      if (in_wb && timer_done && (WbCount != 16'hFFFF)) WbCount <= WbCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: expected values queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_snoop_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_valid;
  logic [2:0] bus_op;
  logic [7:0] bus_addr;
  logic       bus_ready;
  logic       fill_valid;
  logic [7:0] fill_addr;
  logic [2:0] fill_state;
  logic       fill_ready;
  logic [1:0] write_back;
  logic [7:0] wb_addr;
  logic [7:0] query_addr;
  logic [2:0] query_state;
`ifdef SNOOP_STATS_EN
  logic [15:0] snoop_hits, wb_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  snoop_responder #(.ADDR_W(8), .LINES(4), .WB_CYCLES(3)) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .BusValid   (bus_valid),
    .BusOp      (bus_op),
    .BusAddr    (bus_addr),
    .BusReady   (bus_ready),
    .FillValid  (fill_valid),
    .FillAddr   (fill_addr),
    .FillState  (fill_state),
    .FillReady  (fill_ready),
    .WriteBack  (write_back),
    .WbAddr     (wb_addr),
    .QueryAddr  (query_addr),
    .QueryState (query_state)
`ifdef SNOOP_STATS_EN
    ,
    .SnoopHits  (snoop_hits),
    .WbCount    (wb_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input logic [31:0] got);
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic query(input string tag, input logic [7:0] addr, input logic [2:0] exp);
    query_addr = addr;
    push_exp(tag, {29'd0, exp});
    #1;
    pop_check({29'd0, query_state});
  endtask

  task automatic fill(input logic [7:0] addr, input logic [2:0] st);
    fill_valid = 1'b1;
    fill_addr  = addr;
    fill_state = st;
    #1;
    check("fill_ready", {31'd0, fill_ready}, 32'd1);
    tick;
    fill_valid = 1'b0;
  endtask

  task automatic snoop(input logic [2:0] op, input logic [7:0] addr);
    bus_valid = 1'b1;
    bus_op    = op;
    bus_addr  = addr;
    #1;
    check("bus_ready_accept", {31'd0, bus_ready}, 32'd1);
    tick;
    bus_valid = 1'b0;
    bus_op    = 3'b000;
  endtask

  // Runs the write-back window to completion and checks its length and address.
  task automatic wb_window(input string tag, input logic [7:0] exp_addr);
    int n = 0;
    push_exp({tag, "_wbaddr"}, {24'd0, exp_addr});
    while (!bus_ready && n < 10) begin
      if (n == 0) pop_check({24'd0, wb_addr});
      check({tag, "_writeback"}, {30'd0, write_back}, 32'd3);
      check({tag, "_fill_blocked"}, {31'd0, fill_ready}, 32'd0);
      n++;
      tick;
    end
    check({tag, "_wb_cycles"}, n, 32'd3);
    check({tag, "_writeback_end"}, {30'd0, write_back}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; bus_valid = 1'b0; bus_op = 3'b000; bus_addr = 8'h00;
    fill_valid = 1'b0; fill_addr = 8'h00; fill_state = 3'b000; query_addr = 8'h00;
    tick; tick;
    rst_n = 1'b1;
    #1;
    check("rst_bus_ready", {31'd0, bus_ready}, 32'd1);
    check("rst_fill_ready", {31'd0, fill_ready}, 32'd1);
    check("rst_writeback", {30'd0, write_back}, 32'd0);
    check("rst_wbaddr", {24'd0, wb_addr}, 32'd0);
    for (int a = 0; a < 256; a++) query("rst_query", 8'(a), 3'b000);
    tick;

    // Write miss on SHARED line: invalidate, no stall.
    fill(8'h15, 3'b001);
    query("fill_15", 8'h15, 3'b001);
    snoop(3'b010, 8'h15);
    query("wrmiss_15", 8'h15, 3'b000);
    check("wrmiss_no_stall", {31'd0, bus_ready}, 32'd1);
    check("wrmiss_no_wb", {30'd0, write_back}, 32'd0);

    // Read miss on MODIFIED line: 3-cycle write-back, then SHARED.
    fill(8'h22, 3'b010);
    snoop(3'b001, 8'h22);
    query("rd_wb_pending", 8'h22, 3'b010);
    wb_window("rd22", 8'h22);
    query("rd_wb_done", 8'h22, 3'b001);
    check("wbaddr_hold", {24'd0, wb_addr}, 32'h22);

    // Same index, tag mismatch: no effect.
    fill(8'h06, 3'b010);
    snoop(3'b001, 8'h0A);
    check("tagmiss_no_stall", {31'd0, bus_ready}, 32'd1);
    check("tagmiss_no_wb", {30'd0, write_back}, 32'd0);
    query("tagmiss_06", 8'h06, 3'b010);

    // Fill collides with snoop on same index: blocked, then retried.
    bus_valid = 1'b1; bus_op = 3'b011; bus_addr = 8'h11;
    fill_valid = 1'b1; fill_addr = 8'h01; fill_state = 3'b001;
    #1;
    check("collide_fill_ready", {31'd0, fill_ready}, 32'd0);
    tick;
    bus_valid = 1'b0; bus_op = 3'b000; fill_valid = 1'b0;
    query("collide_not_applied", 8'h01, 3'b000);
    fill(8'h01, 3'b001);
    query("fill_retry", 8'h01, 3'b001);
    snoop(3'b011, 8'h01);
    query("inv_hit", 8'h01, 3'b000);

    // Illegal fill state becomes INVALID; reserved op ignored.
    fill(8'h03, 3'b111);
    query("illegal_fill", 8'h03, 3'b000);
    fill(8'h03, 3'b001);
    snoop(3'b100, 8'h03);
    query("reserved_op", 8'h03, 3'b001);

    // Write miss on MODIFIED: write-back then INVALID.
    fill(8'h37, 3'b010);
    snoop(3'b010, 8'h37);
    wb_window("wr37", 8'h37);
    query("wr_wb_done", 8'h37, 3'b000);
`ifdef SNOOP_STATS_EN
    check("stat_hits", {16'd0, snoop_hits}, 32'd4);
    check("stat_wbs", {16'd0, wb_count}, 32'd2);
`endif

    // Reset during the second write-back cycle aborts it.
    fill(8'h33, 3'b010);
    snoop(3'b010, 8'h33);
    check("abort_wb_active", {30'd0, write_back}, 32'd3);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("abort_writeback", {30'd0, write_back}, 32'd0);
    check("abort_bus_ready", {31'd0, bus_ready}, 32'd1);
    check("abort_wbaddr", {24'd0, wb_addr}, 32'd0);
    query("abort_line", 8'h33, 3'b000);
    query("abort_line_22", 8'h22, 3'b000);
`ifdef SNOOP_STATS_EN
    check("abort_hits", {16'd0, snoop_hits}, 32'd0);
    check("abort_wbs", {16'd0, wb_count}, 32'd0);
`endif
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Bus-side snoop responder for the snooping coherence design: the remote cache's half of the protocol. It watches the 3-bit coherence bus driven by the processor-side state machines, looks up a small direct-mapped tag/state array, and invalidates or downgrades lines on snooped misses. Lines held in MODIFIED get a timed write-back with the bus stalled. The local controller installs line states through a fill port, so the block sits between the shared bus and one cache's state store.

## Interface
Parameters:
- ADDR_W, 8, bus address width; index = low IDX_W bits, tag = remaining bits
- LINES, 4, number of direct-mapped lines (power of two, ≥2); IDX_W = log2(LINES)
- WB_CYCLES, 3, write-back duration in cycles (≥1)

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset_n  in  1  synchronous, active-low reset
- BusValid  in  1  snoop transaction present
- BusOp  in  3  000 none, 001 read miss, 010 write miss, 011 invalidate, others ignored
- BusAddr  in  ADDR_W  snooped address
- BusReady  out  1  responder can accept; transfer on BusValid&&BusReady
- FillValid  in  1  local install request
- FillAddr  in  ADDR_W  install address
- FillState  in  3  state to install (INVALID/SHARED/MODIFIED)
- FillReady  out  1  fill applied this cycle when FillValid&&FillReady
- WriteBack  out  2  bit0 write-back active, bit1 abort memory access
- WbAddr  out  ADDR_W  address being written back
- QueryAddr  in  ADDR_W  combinational state query
- QueryState  out  3  state of QueryAddr (INVALID on tag mismatch)

## Operation
- Line states: INVALID 3'b000, SHARED 3'b001, MODIFIED 3'b010. The array holds a tag and a state per line.
- FSM states: IDLE, WB.
- In IDLE, BusReady=1. Accepted op is evaluated against the array contents before the edge. A hit requires tag match and state ≠ INVALID.
  - Read miss, hit SHARED: no change.
  - Read miss, hit MODIFIED: enter WB; line → SHARED at end.
  - Write miss, hit SHARED: line → INVALID at the accept edge.
  - Write miss, hit MODIFIED: enter WB; line → INVALID at end.
  - Invalidate, hit (either state): line → INVALID; no write-back.
  - Miss, op 000, or op ≥100: no change.
- WB: BusReady=0, WriteBack=2'b11, WbAddr = captured address. Down-counter is loaded with WB_CYCLES−1. The line update occurs on the edge where the counter reads 0, with return to IDLE on that same edge.
- Fill: FillReady = (state==IDLE) && !(BusValid && BusOp∈{001,010,011} && FillAddr index == BusAddr index). An applied fill writes the tag and FillState. Snoop has priority on same-index collision, and fills are blocked during WB.
- Illegal FillState (≥3'b011) is written as INVALID.

## Timing
- Reset (Reset_n=0 at edge) forces:
  - all lines INVALID, tags 0
  - FSM IDLE, counter 0
  - WriteBack=2'b00, WbAddr=0
  - BusReady=1 and FillReady=1 from the first cycle after reset
- Reset during WB aborts it: no line update, outputs return to their reset values the next cycle.
- Non-WB snoop: state update is visible on QueryState 1 cycle after the accept edge, and BusReady stays 1, giving back-to-back acceptance.
- WB snoop:
  - BusReady low and WriteBack=2'b11 for exactly WB_CYCLES cycles, starting the cycle after accept.
  - Next accept is possible in the first cycle after WB ends.
- QueryState is purely combinational from the registered array; no bypass of same-cycle updates.
- WbAddr holds its last value after WB ends; WriteBack returns to 2'b00.

## Configuration
- SNOOP_STATS_EN defined: adds outputs SnoopHits (16-bit, counts accepted snoops that hit) and WbCount (16-bit, counts completed write-backs). Both saturate at 16'hFFFF and are cleared by reset.
- SNOOP_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package snoop_pkg holds:
  - line-state constants (INVALID/SHARED/MODIFIED)
  - bus op constants (NONE/RD_MISS/WR_MISS/INV)
  - FSM state typedef
  - WriteBack bit positions
- Sub-module snoop_wb_timer: load/count-down/done counter parameterized by WB_CYCLES. The tag/state array and FSM stay in snoop_responder.

## Test plan
- Reset, then query 0x00..0xFF → all QueryState=000. Check BusReady=1, FillReady=1, WriteBack=00.
- Fill 0x15 SHARED, then snoop write miss 0x15 → QueryState(0x15)=000 one cycle later; BusReady never drops.
- Fill 0x22 MODIFIED, then snoop read miss 0x22 (WB_CYCLES=3) → BusReady=0 and WriteBack=11 for 3 cycles with WbAddr=0x22, then state 001.
- Fill 0x06 MODIFIED, then snoop read miss 0x0A (same index, tag mismatch) → no WB, state of 0x06 stays 010.
- Same-cycle snoop invalidate 0x11 and fill 0x01 SHARED → FillReady=0, fill not applied; fill retried next cycle → state 001.
- Assert Reset_n=0 on 2nd WB cycle of a MODIFIED write miss → next cycle WriteBack=00, BusReady=1, the line INVALID (and SnoopHits=0, WbCount=0 when SNOOP_STATS_EN).
